// File: rtl/spectrum_bar_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_bar_gen
//  Purpose  : Turns a 16-band frame of signed 16-bit spectrum words into
//             4-bit bar heights with fast attack and frame-divided decay.
//             An optional per-band peak-hold marker is built when the macro
//             SPECTRUM_PEAK_HOLD_EN is defined. Without it, o_peak is zero.
//             Bands are processed one per cycle, so a frame takes 18 cycles
//             including the idle cycle.
//  Ports    : i_clk         clock, rising edge
//             i_rst         asynchronous active-high reset
//             i_data[16]    signed band words, band k = i_data[k]
//             i_data_done   strobe: capture i_data as a new frame (idle only)
//             o_level[16]   smoothed bar height per band, 0..15
//             o_peak[16]    peak-hold marker per band, 0..15
//             o_busy        high while a frame is being processed
//             o_frame_done  one-cycle strobe, all outputs final
//  Revision : 1.0  initial release
// ============================================================================
module spectrum_bar_gen #(
    parameter int DECAY_DIV   = 4,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_data [16],
    input  logic        i_data_done,
    output logic [3:0]  o_level [16],
    output logic [3:0]  o_peak [16],
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam logic [3:0] c_FC_LAST = 4'(DECAY_DIV - 1);

    generate
        if (DECAY_DIV < 1 || DECAY_DIV > 16 || HOLD_FRAMES < 0 || HOLD_FRAMES > 15) begin : g_param_check
            $error("spectrum_bar_gen: DECAY_DIV or HOLD_FRAMES out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  band_q, band_d;
    logic        w_capture;
    logic [15:0] buf_q [16];
    logic [3:0]  fc_q;
    logic [3:0]  level_q [16];

    logic [15:0] w_x;
    logic [15:0] w_abs;
    logic [14:0] w_mag;
    logic [3:0]  w_raw;
    logic [3:0]  w_level_old;
    logic [3:0]  w_level_new;
    logic        w_decay;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        band_d    = band_q;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_data_done) begin
                    w_capture = 1'b1;
                    band_d    = 4'd0;
                    state_d   = S_PROC;
                end
            end
            S_PROC: begin
                band_d = band_q + 4'd1;
                if (band_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-band datapath for the band currently addressed by band_q
    // ------------------------------------------------------------------
    always_comb begin
        w_x   = buf_q[band_q];
        w_abs = w_x[15] ? (~w_x + 16'd1) : w_x;
        // Only 0x8000 leaves bit 15 set after negation; clamp it to 32767.
        w_mag = w_abs[15] ? 15'h7FFF : w_abs[14:0];

        w_raw = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (w_mag[i]) begin
                w_raw = 4'(i + 1);
            end
        end

        w_decay     = (fc_q == c_FC_LAST);
        w_level_old = level_q[band_q];
        if (w_raw >= w_level_old) begin
            w_level_new = w_raw;
        end else if (w_decay) begin
            w_level_new = w_level_old - 4'd1;
        end else begin
            w_level_new = w_level_old;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            band_q  <= 4'd0;
            fc_q    <= 4'd0;
            for (int k = 0; k < 16; k++) begin
                buf_q[k]   <= 16'd0;
                level_q[k] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            if (w_capture) begin
                for (int k = 0; k < 16; k++) begin
                    buf_q[k] <= i_data[k];
                end
            end
            if (state_q == S_PROC) begin
                level_q[band_q] <= w_level_new;
            end
            // The frame counter moves once per frame, after all bands have
            // seen the same decay decision.
            if (state_q == S_DONE) begin
                fc_q <= (fc_q == c_FC_LAST) ? 4'd0 : fc_q + 4'd1;
            end
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam logic [3:0] c_HOLD = 4'(HOLD_FRAMES);

    logic [3:0] peak_q [16];
    logic [3:0] hc_q   [16];
    logic [3:0] w_peak_old;
    logic [3:0] w_peak_new;
    logic [3:0] w_hc_new;

    always_comb begin
        w_peak_old = peak_q[band_q];
        w_peak_new = w_peak_old;
        w_hc_new   = hc_q[band_q];
        if (w_raw >= w_peak_old) begin
            w_peak_new = w_raw;
            w_hc_new   = c_HOLD;
        end else if (hc_q[band_q] != 4'd0) begin
            w_hc_new = hc_q[band_q] - 4'd1;
        end else if (w_decay) begin
            // w_peak_old > w_raw >= 0 here, so the decrement cannot wrap.
            w_peak_new = ((w_peak_old - 4'd1) < w_level_new) ? w_level_new : (w_peak_old - 4'd1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 16; k++) begin
                peak_q[k] <= 4'd0;
                hc_q[k]   <= 4'd0;
            end
        end else if (state_q == S_PROC) begin
            peak_q[band_q] <= w_peak_new;
            hc_q[band_q]   <= w_hc_new;
        end
    end

    generate
        for (genvar k = 0; k < 16; k++) begin : g_peak_out
            assign o_peak[k] = peak_q[k];
        end
    endgenerate
`else
    generate
        for (genvar k = 0; k < 16; k++) begin : g_peak_zero
            assign o_peak[k] = 4'd0;
        end
    endgenerate
`endif

    generate
        for (genvar k = 0; k < 16; k++) begin : g_level_out
            assign o_level[k] = level_q[k];
        end
    endgenerate

    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = (state_q == S_DONE);

endmodule
`default_nettype wire
